// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel-plot write path.
//   PIX_H_RES / PIX_V_RES : default screen geometry (320 x 240)
//   COLOUR_W              : colour width in bits
//   FB_ADDR_W             : frame-buffer address width
//   pixel_t               : one plot request {x, y, colour}
//   wb_state_e            : write-buffer mode (IDLE / DRAIN / SWEEP)
//   xy_to_addr()          : linear address y*320 + x built from shifts and adds
package pixel_pkg;

  localparam int PIX_H_RES = 320;
  localparam int PIX_V_RES = 240;
  localparam int COLOUR_W  = 3;
  localparam int FB_ADDR_W = 17;

  typedef struct packed {
    logic [8:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } wb_state_e;

  // y*320 = y*256 + y*64, so two shifts replace the multiplier.
  function automatic logic [FB_ADDR_W-1:0] xy_to_addr(input logic [8:0] x,
                                                       input logic [7:0] y);
    logic [FB_ADDR_W-1:0] yw;
    logic [FB_ADDR_W-1:0] xw;
    yw = {{(FB_ADDR_W-8){1'b0}}, y};
    xw = {{(FB_ADDR_W-9){1'b0}}, x};
    return (yw << 8) + (yw << 6) + xw;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO for plot requests, reusable by any plot producer.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   push_i        : write push_data_i (ignored while full)
//   pop_i         : advance the read side (ignored while empty)
//   pop_data_o    : oldest entry, valid whenever empty_o is low
//   full_o/empty_o: occupancy flags
//   level_o       : exact number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter type T     = pixel_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (level_q == FULL_LEVEL);
  assign empty_o    = (level_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// Consumer end of the pixel-plot interface. Buffers plot requests, converts
// (x,y) to linear frame-buffer addresses and issues single-pixel writes
// under frame-buffer back-pressure. A clear request drains queued plots and
// then sweeps every address with a latched colour.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   plot_valid/plot_ready    : plot handshake; x_in, y_in, colour_in payload
//   clear_req, clear_colour  : start a full-screen fill (honoured in IDLE only)
//   busy                     : clear in progress (drain or sweep)
//   clear_done               : one-cycle pulse after the last fill write
//   fb_we, fb_addr, fb_data  : write to frame buffer; fb_stall holds it
//   level                    : FIFO occupancy
//   oob_count                : saturating count of dropped off-screen plots
module pixel_write_buffer
  import pixel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int H_RES  = PIX_H_RES,
  parameter int V_RES  = PIX_V_RES,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   plot_valid,
  output logic                   plot_ready,
  input  logic [8:0]             x_in,
  input  logic [7:0]             y_in,
  input  logic [COLOUR_W-1:0]    colour_in,
  input  logic                   clear_req,
  input  logic [COLOUR_W-1:0]    clear_colour,
  output logic                   busy,
  output logic                   clear_done,
  output logic                   fb_we,
  output logic [ADDR_W-1:0]      fb_addr,
  output logic [COLOUR_W-1:0]    fb_data,
  input  logic                   fb_stall,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             oob_count
);

  localparam logic [8:0]        X_LIMIT   = 9'(H_RES);
  localparam logic [7:0]        Y_LIMIT   = 8'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  wb_state_e            state_q, state_d;
  logic                 fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]    fb_addr_q, fb_addr_d;
  logic [COLOUR_W-1:0]  fb_data_q, fb_data_d;
  logic [ADDR_W-1:0]    sweep_q, sweep_d;
  logic                 sweep_last_q, sweep_last_d;  // final address already loaded
  logic [COLOUR_W-1:0]  clear_colour_q, clear_colour_d;
  logic                 clear_done_q, clear_done_d;
  logic [7:0]           oob_q, oob_d;

  pixel_t               push_px;
  pixel_t               head_px;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 fifo_push;
  logic                 accept;
  logic                 in_range;
  logic                 fb_hold;
  logic                 fb_xfer;

  // Ready depends only on registered state, never on plot_valid.
  assign plot_ready = (state_q == IDLE) && !fifo_full;
  assign accept     = plot_valid && plot_ready;
  assign in_range   = (x_in < X_LIMIT) && (y_in < Y_LIMIT);
  assign fifo_push  = accept && in_range;
  assign push_px    = '{x: x_in, y: y_in, colour: colour_in};
  assign fb_hold    = fb_we_q && fb_stall;
  assign fb_xfer    = fb_we_q && !fb_stall;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .T     (pixel_t)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (push_px),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_px),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  always_comb begin
    state_d        = state_q;
    fb_we_d        = fb_we_q;
    fb_addr_d      = fb_addr_q;
    fb_data_d      = fb_data_q;
    sweep_d        = sweep_q;
    sweep_last_d   = sweep_last_q;
    clear_colour_d = clear_colour_q;
    clear_done_d   = 1'b0;
    oob_d          = oob_q;
    fifo_pop       = 1'b0;

    if (accept && !in_range && (oob_q != 8'hFF)) begin
      oob_d = oob_q + 8'd1;
    end

    // Output register: hold while stalled, otherwise reload from the active
    // source (sweep counter or FIFO head) or go idle.
    if (!fb_hold) begin
      fb_we_d = 1'b0;
      if (state_q == SWEEP) begin
        if (!sweep_last_q) begin
          fb_we_d   = 1'b1;
          fb_addr_d = sweep_q;
          fb_data_d = clear_colour_q;
          if (sweep_q == LAST_ADDR) begin
            sweep_last_d = 1'b1;
          end else begin
            sweep_d = sweep_q + ADDR_W'(1);
          end
        end
      end else if (!fifo_empty) begin
        fb_we_d   = 1'b1;
        fb_addr_d = ADDR_W'(xy_to_addr(head_px.x, head_px.y));
        fb_data_d = head_px.colour;
        fifo_pop  = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          clear_colour_d = clear_colour;
          state_d        = DRAIN;
        end
      end
      DRAIN: begin
        // Every queued plot must have left the output register first.
        if (fifo_empty && (!fb_we_q || fb_xfer)) begin
          state_d      = SWEEP;
          sweep_d      = '0;
          sweep_last_d = 1'b0;
        end
      end
      SWEEP: begin
        if (sweep_last_q && fb_xfer) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= '0;
      fb_data_q      <= '0;
      sweep_q        <= '0;
      sweep_last_q   <= 1'b0;
      clear_colour_q <= '0;
      clear_done_q   <= 1'b0;
      oob_q          <= '0;
    end else begin
      state_q        <= state_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_data_q      <= fb_data_d;
      sweep_q        <= sweep_d;
      sweep_last_q   <= sweep_last_d;
      clear_colour_q <= clear_colour_d;
      clear_done_q   <= clear_done_d;
      oob_q          <= oob_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign clear_done = clear_done_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign oob_count  = oob_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer. A reference model tracks the
// ordered list of writes the frame buffer must receive (accepted on-screen
// plots as y*320+x, then a full sweep per accepted clear), the expected
// dropped-plot count and the clear_done pulse.
module tb_pixel_write_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 17;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int LAST   = 320 * 240 - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              plot_valid = 1'b0;
  logic              plot_ready;
  logic [8:0]        x_in = '0;
  logic [7:0]        y_in = '0;
  logic [2:0]        colour_in = '0;
  logic              clear_req = 1'b0;
  logic [2:0]        clear_colour = '0;
  logic              busy;
  logic              clear_done;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [2:0]        fb_data;
  logic              fb_stall = 1'b0;
  logic [LVL_W-1:0]  level;
  logic [7:0]        oob_count;

  pixel_write_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .plot_valid(plot_valid), .plot_ready(plot_ready),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .busy(busy), .clear_done(clear_done),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_stall(fb_stall),
    .level(level), .oob_count(oob_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int exp_q[$];          // {colour, addr} of pending plot writes, in order
  bit sweep_on = 0;
  bit clr_pending = 0;
  bit done_exp = 0;
  int sweep_next = 0;
  int sweep_col = 0;
  int oob_exp = 0;
  int n_accepted = 0;
  int done_pulses = 0;

  initial forever begin
    @(negedge clock);
    if (reset) begin
      exp_q.delete();
      sweep_on = 0;
      clr_pending = 0;
      done_exp = 0;
      oob_exp = 0;
    end else begin
      check("clear_done", clear_done, done_exp);
      if (clear_done) done_pulses++;
      check("busy", busy, clr_pending);
      if (clr_pending) check("ready_during_clear", plot_ready, 0);
      done_exp = 0;
      check("oob_count", oob_count, oob_exp);
      check("level_bound", level <= DEPTH, 1);
      if (fb_we) begin
        if (exp_q.size() > 0) begin
          check("plot_wr", {fb_data, fb_addr}, exp_q[0]);
          if (!fb_stall) void'(exp_q.pop_front());
        end else if (sweep_on) begin
          check("sweep_wr", {fb_data, fb_addr}, sweep_col * (1 << 17) + sweep_next);
          if (!fb_stall) begin
            if (sweep_next == LAST) begin
              sweep_on = 0;
              clr_pending = 0;
              done_exp = 1;
            end else begin
              sweep_next++;
            end
          end
        end else begin
          check("spurious_we", fb_we, 0);
        end
      end
      if (plot_valid && plot_ready) begin
        n_accepted++;
        if (x_in < 320 && y_in < 240)
          exp_q.push_back((int'(colour_in) << 17) + int'(y_in) * 320 + int'(x_in));
        else if (oob_exp < 255)
          oob_exp++;
      end
      if (clear_req && !clr_pending) begin
        clr_pending = 1;
        sweep_on = 1;
        sweep_next = 0;
        sweep_col = int'(clear_colour);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    plot_valid = 1'b0;
    clear_req = 1'b0;
    fb_stall = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // Present one plot and hold it until accepted; returns just after the accept edge.
  task automatic send_plot(input int x, input int y, input int c);
    x_in = 9'(x);
    y_in = 8'(y);
    colour_in = 3'(c);
    plot_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      wait_neg();
      if (plot_ready) begin
        tick();
        plot_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    plot_valid = 1'b0;
  endtask

  int base;
  int pulses0;
  bit found;

  initial begin
    // Reset state
    do_reset();
    wait_neg();
    check("rst_level", level, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_oob", oob_count, 0);
    check("rst_ready", plot_ready, 1);

    // Single plot latency and address
    tick();
    send_plot(5, 3, 4);
    wait_neg();
    check("no_bypass_we", fb_we, 0);
    check("lat_level1", level, 1);
    wait_neg();
    check("lat_we", fb_we, 1);
    check("lat_addr", fb_addr, 965);
    check("lat_data", fb_data, 4);
    check("lat_level0", level, 0);

    // Fill under stall: 16 in FIFO + 1 in output register
    tick();
    fb_stall = 1'b1;
    base = n_accepted;
    for (int i = 0; i < 20; i++) begin
      x_in = 9'(i * 7);
      y_in = 8'(i + 10);
      colour_in = 3'(i % 8);
      plot_valid = 1'b1;
      tick();
    end
    plot_valid = 1'b0;
    wait_neg();
    check("stall_accepted", n_accepted - base, 17);
    check("stall_ready", plot_ready, 0);
    check("stall_level", level, DEPTH);
    check("stall_we", fb_we, 1);
    tick();
    fb_stall = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wait_neg();
      check("b2b_we", fb_we, 1);
    end
    wait_neg();
    check("b2b_end_we", fb_we, 0);
    check("b2b_level", level, 0);
    check("b2b_pending", exp_q.size(), 0);

    // Randomised plotting with random back-pressure
    tick();
    for (int i = 0; i < 500; i++) begin
      plot_valid = ($urandom_range(0, 9) < 6);
      x_in = 9'($urandom_range(0, 335));
      y_in = 8'($urandom_range(0, 250));
      colour_in = 3'($urandom);
      fb_stall = ($urandom_range(0, 9) < 3);
      tick();
    end
    plot_valid = 1'b0;
    fb_stall = 1'b0;
    for (int k = 0; k < 100; k++) begin
      wait_neg();
      if (exp_q.size() == 0 && !fb_we) break;
    end
    check("rand_drained", exp_q.size(), 0);
    check("rand_level", level, 0);

    // Range boundary and oob saturation
    do_reset();
    send_plot(319, 239, 7);
    send_plot(320, 0, 1);
    repeat (4) wait_neg();
    check("oob_one", oob_count, 1);
    check("edge_written", exp_q.size(), 0);
    check("oob_no_we", fb_we, 0);
    tick();
    for (int i = 0; i < 300; i++) begin
      x_in = 9'($urandom_range(320, 511));
      y_in = 8'($urandom_range(0, 255));
      colour_in = 3'($urandom);
      plot_valid = 1'b1;
      tick();
    end
    plot_valid = 1'b0;
    wait_neg();
    wait_neg();
    check("oob_sat", oob_count, 255);
    check("oob_sat_we", fb_we, 0);

    // Clear: queued plots first, then full sweep with early random stalls
    tick();
    fb_stall = 1'b1;
    send_plot(10, 20, 1);
    send_plot(100, 200, 3);
    send_plot(319, 0, 6);
    clear_req = 1'b1;
    clear_colour = 3'd2;
    tick();
    clear_req = 1'b0;
    pulses0 = done_pulses;
    for (int cyc = 0; cyc < 80000; cyc++) begin
      if (done_pulses > pulses0) break;
      fb_stall = (cyc < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
      clear_req = (cyc == 100);
      clear_colour = (cyc == 100) ? 3'd5 : 3'd2;
      plot_valid = (cyc >= 200 && cyc < 210);
      x_in = 9'($urandom_range(0, 319));
      y_in = 8'($urandom_range(0, 239));
      tick();
    end
    plot_valid = 1'b0;
    clear_req = 1'b0;
    fb_stall = 1'b0;
    wait_neg();
    check("clr_done_once", done_pulses - pulses0, 1);
    check("clr_busy_after", busy, 0);
    check("clr_ready_after", plot_ready, 1);
    repeat (3) wait_neg();
    check("clr_done_still_once", done_pulses - pulses0, 1);

    // Reset in the middle of a sweep
    tick();
    clear_req = 1'b1;
    clear_colour = 3'd3;
    tick();
    clear_req = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      tick();
      fb_stall = 1'($urandom_range(0, 1));
      wait_neg();
      if (fb_we && fb_addr == ADDR_W'(1000)) begin
        found = 1;
        break;
      end
    end
    check("sweep_reached_1000", found, 1);
    pulses0 = done_pulses;
    reset = 1'b1;
    wait_neg();
    check("midrst_we", fb_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", clear_done, 0);
    check("midrst_level", level, 0);
    tick();
    reset = 1'b0;
    fb_stall = 1'b0;
    wait_neg();
    check("midrst_ready", plot_ready, 1);
    repeat (20) wait_neg();
    check("midrst_no_done", done_pulses - pulses0, 0);
    check("midrst_idle_we", fb_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
